// File: rtl/dtoa_serial_tx_if.sv
// dtoa_serial_tx_if: valid/ready sample stream into the serial DAC transmitter
interface dtoa_serial_tx_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, in_valid, input in_ready);
  modport slave(input in_data, in_valid, output in_ready);
endinterface

// File: rtl/dtoa_serial_tx.sv
// dtoa_serial_tx: FIFO-buffered PCM samples shifted MSB-first to a serial DAC
module dtoa_serial_tx #(
  parameter int WIDTH = 16,
  parameter int CLK_DIV = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  dtoa_serial_tx_if.slave s,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic busy,
  output logic sclk,
  output logic sdata,
  output logic cs_n
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DESEL} state_t;
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] head, sr_q, sr_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  state_t st_q, st_d;
  logic sclk_q, sclk_d, sdata_q, sdata_d, cs_n_q, cs_n_d;
  logic push, pop, last;
  assign s.in_ready = !rst && cnt_q < CW'(FIFO_DEPTH);
  assign push = s.in_valid && s.in_ready;
  assign pop = st_q == IDLE && cnt_q != '0;
  assign head = mem_q[rp_q];
  assign last = div_q == '0;
  assign fifo_count = cnt_q;
  assign busy = st_q != IDLE;
  assign sclk = sclk_q;
  assign sdata = sdata_q;
  assign cs_n = cs_n_q;
  // FIFO pointers and occupancy; full blocks push even when a pop is pending
  always_comb begin
    wp_d = wp_q + AW'(push);
    rp_d = rp_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  // Sample storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= s.in_data;
  // Frame sequencer: each phase lasts CLK_DIV clocks, sdata moves only while sclk is low
  always_comb begin
    st_d = st_q;
    div_d = last ? div_q : div_q - DW'(1);
    sr_d = sr_q;
    bit_d = bit_q;
    sclk_d = sclk_q;
    sdata_d = sdata_q;
    cs_n_d = cs_n_q;
    case (st_q)
      IDLE: if (pop) begin
        st_d = SETUP;
        sr_d = head;
        sdata_d = head[WIDTH-1];
        cs_n_d = 1'b0;
        div_d = RELOAD;
        bit_d = '0;
      end
      SETUP: if (last) begin
        st_d = HIGH;
        sclk_d = 1'b1;
        div_d = RELOAD;
      end
      HIGH: if (last) begin
        st_d = LOW;
        sclk_d = 1'b0;
        div_d = RELOAD;
        bit_d = bit_q + BW'(1);
        sr_d = bit_q != BW'(WIDTH - 1) ? sr_q << 1 : sr_q;
        sdata_d = bit_q != BW'(WIDTH - 1) ? sr_q[WIDTH-2] : sdata_q;
      end
      LOW: if (last) begin
        div_d = RELOAD;
        st_d = bit_q == BW'(WIDTH) ? DESEL : HIGH;
        sclk_d = bit_q != BW'(WIDTH);
        cs_n_d = bit_q == BW'(WIDTH);
        sdata_d = bit_q == BW'(WIDTH) ? 1'b0 : sdata_q;
      end
      DESEL: st_d = last ? IDLE : DESEL;
      default: st_d = IDLE;
    endcase
  end
  // State registers; reset aborts any frame and discards buffered samples
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= IDLE;
      div_q <= '0;
      sr_q <= '0;
      bit_q <= '0;
      sclk_q <= 1'b0;
      sdata_q <= 1'b0;
      cs_n_q <= 1'b1;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      div_q <= div_d;
      sr_q <= sr_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      sdata_q <= sdata_d;
      cs_n_q <= cs_n_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_dtoa_serial_tx.sv
// tb_dtoa_serial_tx: random and directed stimulus against a frame-timing reference model
module tb_dtoa_serial_tx;
  localparam int W = 16;
  logic clk = 0, rst = 1;
  logic [2:0] cnt_a, cnt_b;
  logic busy_a, sclk_a, sd_a, cs_a, busy_b, sclk_b, sd_b, cs_b;
  int n_vec = 0, n_err = 0, cyc = 0;
  int inf [2], st [2], qh [2], qt [2], nb [2], lw [2];
  logic [15:0] cur [2], dw [2];
  logic pcs [2], psc [2];
  logic [15:0] qm [2][1024];
  logic ra, aa, ab;
  logic [15:0] da, db;
  dtoa_serial_tx_if #(.WIDTH(W)) ifa ();
  dtoa_serial_tx_if #(.WIDTH(W)) ifb ();
  dtoa_serial_tx #(.WIDTH(W), .CLK_DIV(2), .FIFO_DEPTH(4)) ua (
    .clk(clk), .rst(rst), .s(ifa), .fifo_count(cnt_a), .busy(busy_a),
    .sclk(sclk_a), .sdata(sd_a), .cs_n(cs_a));
  dtoa_serial_tx #(.WIDTH(W), .CLK_DIV(1), .FIFO_DEPTH(4)) ub (
    .clk(clk), .rst(rst), .s(ifb), .fifo_count(cnt_b), .busy(busy_b),
    .sclk(sclk_b), .sdata(sd_b), .cs_n(cs_b));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of the reference: FIFO as a queue, frame waveform from elapsed time since cs_n fall
  task automatic step(input int i, input int cd, input logic r, input logic acc, input logic [15:0] din,
                      input logic cs, input logic sc, input logic sd, input logic bz, input logic rdy,
                      input logic [2:0] cnt);
    int per, lo, t, k;
    logic e_cs, e_sc, e_sd;
    per = cd * (2 + 2 * W);
    lo = cd * (1 + 2 * W);
    if (r) begin
      inf[i] = 0;
      qh[i] = qt[i];
    end else begin
      if (inf[i] != 0 && cyc - st[i] == per) inf[i] = 0;
      else if (inf[i] == 0 && qt[i] != qh[i]) begin
        inf[i] = 1;
        st[i] = cyc;
        cur[i] = qm[i][qh[i] % 1024];
        qh[i]++;
        nb[i] = 0;
        dw[i] = 0;
        lw[i] = 0;
      end
      if (acc) begin
        qm[i][qt[i] % 1024] = din;
        qt[i]++;
      end
    end
    t = cyc - st[i];
    e_cs = !(inf[i] != 0 && t < lo);
    e_sc = !e_cs && t >= cd && ((t - cd) / cd) % 2 == 0;
    k = t < cd ? 0 : (t - cd) / (2 * cd) + (((t - cd) % (2 * cd)) >= cd ? 1 : 0);
    if (k > W - 1) k = W - 1;
    e_sd = !e_cs && cur[i][W-1-k];
    check(i == 0 ? "cs_n_a" : "cs_n_b", 32'(cs), 32'(e_cs));
    check(i == 0 ? "sclk_a" : "sclk_b", 32'(sc), 32'(e_sc));
    check(i == 0 ? "sdata_a" : "sdata_b", 32'(sd), 32'(e_sd));
    check(i == 0 ? "busy_a" : "busy_b", 32'(bz), 32'(inf[i] != 0));
    check(i == 0 ? "count_a" : "count_b", 32'(cnt), 32'(qt[i] - qh[i]));
    check(i == 0 ? "ready_a" : "ready_b", 32'(rdy), 32'(!r && qt[i] - qh[i] < 4));
    if (!cs) lw[i]++;
    if (!cs && sc && !psc[i]) begin
      dw[i] = {dw[i][14:0], sd};
      nb[i]++;
    end
    if (!r && cs && !pcs[i]) begin
      check(i == 0 ? "word_a" : "word_b", 32'(dw[i]), 32'(cur[i]));
      check(i == 0 ? "rises_a" : "rises_b", 32'(nb[i]), 32'(W));
      check(i == 0 ? "cs_low_a" : "cs_low_b", 32'(lw[i]), 32'(lo));
    end
    pcs[i] = cs;
    psc[i] = sc;
  endtask

  always @(posedge clk) begin
    ra = rst;
    aa = ifa.in_valid && ifa.in_ready;
    ab = ifb.in_valid && ifb.in_ready;
    da = ifa.in_data;
    db = ifb.in_data;
    #1;
    cyc++;
    step(0, 2, ra, aa, da, cs_a, sclk_a, sd_a, busy_a, ifa.in_ready, cnt_a);
    step(1, 1, ra, ab, db, cs_b, sclk_b, sd_b, busy_b, ifb.in_ready, cnt_b);
  end

  task automatic push(input int i, input logic [15:0] d);
    int n = 0;
    if (i == 0) begin
      ifa.in_valid = 1; ifa.in_data = d;
      while (!ifa.in_ready && n < 2000) begin @(negedge clk); n++; end
      check("push_a", 32'(ifa.in_ready), 1);
    end else begin
      ifb.in_valid = 1; ifb.in_data = d;
      while (!ifb.in_ready && n < 2000) begin @(negedge clk); n++; end
      check("push_b", 32'(ifb.in_ready), 1);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    ifa.in_valid = 0;
    ifb.in_valid = 0;
    while ((i == 0 ? (busy_a || cnt_a != 0) : (busy_b || cnt_b != 0)) && n < 6000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check(i == 0 ? "idle_a" : "idle_b", 32'(i == 0 ? busy_a : busy_b), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      inf[i] = 0; st[i] = 0; qh[i] = 0; qt[i] = 0; nb[i] = 0; lw[i] = 0;
      cur[i] = 0; dw[i] = 0; pcs[i] = 1; psc[i] = 0;
    end
    ifa.in_valid = 0; ifa.in_data = 0;
    ifb.in_valid = 0; ifb.in_data = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    push(0, 16'hA5C3);
    wait_idle(0);
    for (int k = 1; k <= 6; k++) push(0, 16'(k));
    wait_idle(0);
    for (int k = 0; k < 8; k++) push(0, 16'($urandom));
    wait_idle(0);
    push(0, 16'h8000);
    push(0, 16'h7FFF);
    wait_idle(0);
    push(0, 16'h1111);
    push(0, 16'h2222);
    push(0, 16'h3333);
    ifa.in_valid = 0;
    n = 0;
    while (cs_a && n < 200) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    repeat (80) @(negedge clk);
    push(1, 16'hFFFF);
    wait_idle(1);
    for (int c = 0; c < 3000; c++) begin
      ifa.in_valid = $urandom_range(0, 3) == 0;
      ifa.in_data = 16'($urandom);
      ifb.in_valid = $urandom_range(0, 2) == 0;
      ifb.in_data = 16'($urandom);
      rst = $urandom_range(0, 799) == 0;
      @(negedge clk);
    end
    rst = 0;
    wait_idle(0);
    wait_idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
